if_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer in front of the 128-entry instruction memory (im).

---
 rtl/if_fetch_ctrl_pkg.sv | 29 ++
 rtl/if_fetch_ctrl_if.sv | 29 ++
 rtl/if_fetch_ctrl_fifo.sv | 66 ++++++
 rtl/if_fetch_ctrl.sv | 84 ++++++++
 tb/tb_if_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, FSM states, queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_ctrl_pkg;

    localparam int XLEN  = 32;
    // Wide enough for occupancy 0..4, the largest legal queue depth.
    localparam int CNT_W = 3;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // One prefetch queue slot: the byte PC and the word fetched from it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    // im is word addressed; the two byte-offset bits are dropped.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_pc);
        return {2'b00, byte_pc[XLEN-1:2]};
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of fetch-side signals: im address/data, hold/redirect control, decode handshake.
// Latency: n/a (wiring only).
// Backpressure: inst_ready_i from decode stalls the queue head.
// master = fetch controller, slave = im + pipeline control + decode.
interface if_fetch_ctrl_if;
    import if_fetch_ctrl_pkg::*;

    logic [XLEN-1:0]  im_addr_o;
    logic [XLEN-1:0]  im_data_i;
    logic             hold_i;
    logic             redirect_i;
    logic [XLEN-1:0]  redirect_pc_i;
    logic             inst_valid_o;
    logic             inst_ready_i;
    logic [XLEN-1:0]  inst_o;
    logic [XLEN-1:0]  inst_pc_o;
    logic [CNT_W-1:0] fq_count_o;

    modport master (
        output im_addr_o, inst_valid_o, inst_o, inst_pc_o, fq_count_o,
        input  im_data_i, hold_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  im_addr_o, inst_valid_o, inst_o, inst_pc_o, fq_count_o,
        output im_data_i, hold_i, redirect_i, redirect_pc_i, inst_ready_i
    );

endinterface

// File: rtl/if_fetch_ctrl_fifo.sv
// Shift-register prefetch queue of {pc, inst}; slot 0 is the registered head.
// Latency: pushed entry reaches the head outputs 1 cycle after push when queue empty.
// Backpressure: caller must not push when full without popping; flush overrides push/pop.
// Ports: clk_i/rst_ni, push_i/pop_i/flush_i, din_i, head_o, head_vld_o, count_o.
module if_fetch_ctrl_fifo
    import if_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fq_entry_t        din_i,
    output fq_entry_t        head_o,
    output logic             head_vld_o,
    output logic [CNT_W-1:0] count_o
);

    fq_entry_t        ent_q [DEPTH];
    fq_entry_t        ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wr_idx;

    always_comb begin
        ent_d  = ent_q;
        cnt_d  = cnt_q;
        // A simultaneous pop shifts everything down first, so the write slot moves down too.
        wr_idx = cnt_q - CNT_W'(pop_i);
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            if (pop_i) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    ent_d[i] = ent_q[i+1];
                end
            end
            if (push_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx) begin
                        ent_d[i] = din_i;
                    end
                end
            end
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o     = ent_q[0];
    assign head_vld_o = (cnt_q != '0);
    assign count_o    = cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns fetch PC, drives im, queues {pc,inst} for decode.
// Latency: fetched word appears on inst_o 1 cycle after its push; first valid 2 cycles after reset.
// Backpressure: decode ready stalls head; full queue stops fetch; hold freezes fetch; redirect flushes.
// Ports: clk_i, rst_ni, bus (if_fetch_ctrl_if.master) carrying im, control and decode signals.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              FQ_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    if_fetch_ctrl_if.master       bus
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fpc_q, fpc_d;
    logic             push, pop;
    fq_entry_t        head;
    fq_entry_t        din;
    logic             head_vld;
    logic [CNT_W-1:0] count;

    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign pop  = head_vld & bus.inst_ready_i & ~bus.redirect_i;
    assign push = (state_q == ST_RUN) & ~bus.hold_i & ~bus.redirect_i &
                  ((count < DEPTH_C) | pop);

    assign din.pc   = fpc_q;
    assign din.inst = bus.im_data_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            // One idle cycle lets im settle after reset; hold and redirect do not delay it.
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (bus.hold_i && !bus.redirect_i) state_d = ST_HOLD;
            ST_HOLD: if (!bus.hold_i && !bus.redirect_i) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fpc_d = fpc_q;
        if (bus.redirect_i) begin
            fpc_d = bus.redirect_pc_i & ~32'h3;
        end else if (push) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
            fpc_q   <= RESET_PC & ~32'h3;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    if_fetch_ctrl_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (bus.redirect_i),
        .din_i      (din),
        .head_o     (head),
        .head_vld_o (head_vld),
        .count_o    (count)
    );

    assign bus.im_addr_o    = word_addr(fpc_q);
    assign bus.inst_valid_o = head_vld;
    assign bus.inst_o       = head.inst;
    assign bus.inst_pc_o    = head.pc;
    assign bus.fq_count_o   = count;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: two instances (depth 2 / reset PC 0, depth 4 / reset PC FFFF_FFF8).
// Directed table plus random traffic, both checked each cycle against a queue-level model.
// Inputs driven at posedge+1, outputs sampled at posedge+1 after the model step.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        h     = 1'b0;
    logic        rd    = 1'b0;
    logic        rdy   = 1'b0;
    logic [31:0] rpc   = '0;
    logic [31:0] imem [128];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl_if ifc0 ();
    if_fetch_ctrl_if ifc1 ();

    assign ifc0.hold_i        = h;
    assign ifc0.redirect_i    = rd;
    assign ifc0.redirect_pc_i = rpc;
    assign ifc0.inst_ready_i  = rdy;
    assign ifc0.im_data_i     = imem[ifc0.im_addr_o[6:0]];
    assign ifc1.hold_i        = h;
    assign ifc1.redirect_i    = rd;
    assign ifc1.redirect_pc_i = rpc;
    assign ifc1.inst_ready_i  = rdy;
    assign ifc1.im_data_i     = imem[ifc1.im_addr_o[6:0]];

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifc0));
    if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifc1));

    // ---------------- reference model ----------------
    int          m_depth [2];
    logic [31:0] m_rst   [2];
    logic [31:0] m_fpc   [2];
    logic [31:0] m_qpc   [2][8];
    int          m_n     [2];
    bit          m_boot  [2];
    bit          m_held  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset(input int i);
        m_n[i]    = 0;
        m_fpc[i]  = m_rst[i] & ~32'h3;
        m_boot[i] = 1'b1;
        m_held[i] = 1'b0;
    endtask

    task automatic m_step(input int i);
        bit pop, push;
        if (rd) begin
            m_n[i]   = 0;
            m_fpc[i] = rpc & ~32'h3;
            m_boot[i] = 1'b0;
        end else begin
            pop  = (m_n[i] > 0) && rdy;
            push = !m_boot[i] && !m_held[i] && !h && ((m_n[i] < m_depth[i]) || pop);
            if (pop) begin
                for (int k = 0; k < 7; k++) m_qpc[i][k] = m_qpc[i][k+1];
                m_n[i]--;
            end
            if (push) begin
                m_qpc[i][m_n[i]] = m_fpc[i];
                m_n[i]++;
                m_fpc[i] = m_fpc[i] + 32'd4;
            end
            if (m_boot[i]) m_boot[i] = 1'b0;
            else           m_held[i] = h;
        end
    endtask

    task automatic m_check(input int i);
        logic        v;
        logic [2:0]  cnt;
        logic [31:0] pc, inst, addr, hp;
        if (i == 0) begin
            v = ifc0.inst_valid_o; cnt = ifc0.fq_count_o; pc = ifc0.inst_pc_o;
            inst = ifc0.inst_o; addr = ifc0.im_addr_o;
        end else begin
            v = ifc1.inst_valid_o; cnt = ifc1.fq_count_o; pc = ifc1.inst_pc_o;
            inst = ifc1.inst_o; addr = ifc1.im_addr_o;
        end
        chk($sformatf("d%0d_valid", i), 32'(v), 32'(m_n[i] > 0));
        chk($sformatf("d%0d_count", i), 32'(cnt), 32'(m_n[i]));
        chk($sformatf("d%0d_addr", i), addr, m_fpc[i] >> 2);
        if (m_n[i] > 0) begin
            hp = m_qpc[i][0];
            chk($sformatf("d%0d_pc", i), pc, hp);
            chk($sformatf("d%0d_inst", i), inst, imem[hp[8:2]]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        m_step(0); m_step(1);
        m_check(0); m_check(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid0"}, 32'(ifc0.inst_valid_o), 32'd0);
        chk({tag, "_inst0"},  ifc0.inst_o, 32'd0);
        chk({tag, "_pc0"},    ifc0.inst_pc_o, 32'd0);
        chk({tag, "_count0"}, 32'(ifc0.fq_count_o), 32'd0);
        chk({tag, "_addr0"},  ifc0.im_addr_o, 32'd0);
        chk({tag, "_valid1"}, 32'(ifc1.inst_valid_o), 32'd0);
        chk({tag, "_inst1"},  ifc1.inst_o, 32'd0);
        chk({tag, "_addr1"},  ifc1.im_addr_o, 32'h3FFF_FFFE);
    endtask

    // ---------------- directed table (checked on dut0) ----------------
    typedef struct {
        logic        h;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [2:0]  ecnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic hh, input logic rr, input logic [31:0] pp,
                                input logic yy, input logic ev, input logic [31:0] epc,
                                input logic [31:0] ei, input logic [2:0] ec,
                                input logic [31:0] ea);
        vec_t r;
        r.h = hh; r.rd = rr; r.rpc = pp; r.rdy = yy;
        r.ev = ev; r.epc = epc; r.einst = ei; r.ecnt = ec; r.eaddr = ea;
        return r;
    endfunction

    logic [31:0] wrap_pc [3];

    initial begin
        for (int k = 0; k < 128; k++) imem[k] = k;
        m_depth[0] = 2;  m_depth[1] = 4;
        m_rst[0] = 32'h0000_0000;  m_rst[1] = 32'hFFFF_FFF8;
        wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;

        //            h  rd rpc      rdy  ev  pc        inst cnt addr
        tbl[0]  = mk(0, 0, 32'h0,   1,   0, 32'h0,   0,   0, 32'h00); // BOOT, no fetch
        tbl[1]  = mk(0, 0, 32'h0,   1,   1, 32'h0,   0,   1, 32'h01);
        tbl[2]  = mk(0, 0, 32'h0,   1,   1, 32'h4,   1,   1, 32'h02);
        tbl[3]  = mk(0, 0, 32'h0,   1,   1, 32'h8,   2,   1, 32'h03);
        tbl[4]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   2,   2, 32'h04); // decode stalls
        tbl[5]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   2,   2, 32'h04); // full: fpc frozen
        tbl[6]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   2,   2, 32'h04);
        tbl[7]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   2,   2, 32'h04);
        tbl[8]  = mk(0, 0, 32'h0,   0,   1, 32'h8,   2,   2, 32'h04);
        tbl[9]  = mk(0, 0, 32'h0,   1,   1, 32'hC,   3,   2, 32'h05); // push+pop while full
        tbl[10] = mk(0, 0, 32'h0,   1,   1, 32'h10,  4,   2, 32'h06);
        tbl[11] = mk(0, 1, 32'h43,  1,   0, 32'h0,   0,   0, 32'h10); // redirect while full
        tbl[12] = mk(0, 0, 32'h0,   1,   1, 32'h40,  16,  1, 32'h11);
        tbl[13] = mk(0, 0, 32'h0,   1,   1, 32'h44,  17,  1, 32'h12);
        tbl[14] = mk(1, 0, 32'h0,   1,   0, 32'h0,   0,   0, 32'h12); // hold: drain
        tbl[15] = mk(1, 0, 32'h0,   1,   0, 32'h0,   0,   0, 32'h12);
        tbl[16] = mk(1, 0, 32'h0,   1,   0, 32'h0,   0,   0, 32'h12);
        tbl[17] = mk(0, 0, 32'h0,   1,   0, 32'h0,   0,   0, 32'h12); // HOLD->RUN bubble
        tbl[18] = mk(0, 0, 32'h0,   1,   1, 32'h48,  18,  1, 32'h13);
        tbl[19] = mk(0, 0, 32'h0,   1,   1, 32'h4C,  19,  1, 32'h14);
        tbl[20] = mk(1, 0, 32'h0,   1,   0, 32'h0,   0,   0, 32'h14);
        tbl[21] = mk(1, 1, 32'h300, 1,   0, 32'h0,   0,   0, 32'hC0); // redirect in HOLD
        tbl[22] = mk(0, 0, 32'h0,   1,   0, 32'h0,   0,   0, 32'hC0);
        tbl[23] = mk(0, 0, 32'h0,   1,   1, 32'h300, 64,  1, 32'hC1); // im aliases upper bits
        tbl[24] = mk(0, 0, 32'h0,   1,   1, 32'h304, 65,  1, 32'hC2);

        // ---- reset state ----
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        #1;
        rst_n = 1'b1;
        m_reset(0); m_reset(1);

        // ---- directed table ----
        for (int i = 0; i < 25; i++) begin
            h = tbl[i].h; rd = tbl[i].rd; rpc = tbl[i].rpc; rdy = tbl[i].rdy;
            @(posedge clk);
            #1;
            m_step(0); m_step(1);
            chk($sformatf("tbl%0d_valid", i), 32'(ifc0.inst_valid_o), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 32'(ifc0.fq_count_o), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_addr", i), ifc0.im_addr_o, tbl[i].eaddr);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i), ifc0.inst_pc_o, tbl[i].epc);
                chk($sformatf("tbl%0d_inst", i), ifc0.inst_o, tbl[i].einst);
            end
            if (i >= 1 && i <= 3) begin
                chk($sformatf("wrap_pc%0d", i), ifc1.inst_pc_o, wrap_pc[i-1]);
            end
            if (i == 2) chk("wrap_addr", ifc1.im_addr_o, 32'h0);
            m_check(0); m_check(1);
        end

        // ---- random traffic ----
        for (int n = 0; n < 300; n++) begin
            h   = ($urandom_range(0, 5) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = $urandom;
            rdy = ($urandom_range(0, 2) != 0);
            cycle();
        end

        // ---- async reset mid-stream with a redirect pending ----
        rd  = 1'b1;
        rpc = 32'h0000_0124;
        rdy = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        m_reset(0); m_reset(1);
        @(posedge clk);
        #1;
        rd = 1'b0; h = 1'b1; rdy = 1'b1;  // hold during BOOT must not delay RUN
        #1;
        rst_n = 1'b1;
        cycle();
        chk("boot_no_fetch", 32'(ifc0.inst_valid_o), 32'd0);
        h = 1'b0;
        cycle();
        chk("restart_valid0", 32'(ifc0.inst_valid_o), 32'd1);
        chk("restart_pc0", ifc0.inst_pc_o, 32'h0000_0000);
        chk("restart_pc1", ifc1.inst_pc_o, 32'hFFFF_FFF8);

        for (int n = 0; n < 300; n++) begin
            h   = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
